// File: rtl/fib_word_packer.sv
// fib_word_packer: pairs 8-bit Fibonacci samples into 16-bit words queued in a DEPTH-entry FIFO.
// Optional sequence checker enabled by defining FIB_PACK_SEQ_CHECK_EN.
module fib_word_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     smp_valid,
  input  logic [7:0]               smp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic                     out_wrap,
  output logic                     drop_sticky,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     seq_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {EMPTY, HALF} state_t;
  state_t state, state_n;
  logic [7:0] hold, hold_n;
  logic [16:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push, pop, full, wr;
  always_comb begin
    state_n = smp_valid ? (state == EMPTY ? HALF : EMPTY) : state;
    hold_n = (smp_valid && state == EMPTY) ? smp_data : hold;
    push = smp_valid && state == HALF;
    full = fifo_count == (AW+1)'(DEPTH);
    pop = out_valid && out_ready;
    wr = push && (!full || pop);
  end
  assign out_valid = fifo_count != '0;
  assign out_data = mem[rptr][15:0];
  assign out_wrap = mem[rptr][16];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      hold <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      drop_sticky <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      if (wr) begin
        mem[wptr] <= {smp_data < hold, hold, smp_data};
        wptr <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      fifo_count <= (wr && !pop) ? fifo_count + 1'b1 : (pop && !wr) ? fifo_count - 1'b1 : fifo_count;
      if (push && !wr) drop_sticky <= 1'b1;
    end
  end
`ifdef FIB_PACK_SEQ_CHECK_EN
  logic [7:0] prev1, prev2;
  logic [1:0] seen;
  logic [7:0] expect_next;
  assign expect_next = prev1 + prev2;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev1 <= '0;
      prev2 <= '0;
      seen <= '0;
      seq_err <= 1'b0;
    end else if (smp_valid) begin
      if (seen == 2'd2 && smp_data != expect_next) seq_err <= 1'b1;
      prev2 <= prev1;
      prev1 <= smp_data;
      seen <= seen == 2'd2 ? seen : seen + 2'd1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif
endmodule

// File: doc/fib_word_packer.md
FIB_WORD_PACKER -- requirements
Module: fib_word_packer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, FIFO depth in packed words; legal values are powers of two, minimum 2.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 Port clk SHALL be input, 1 bit: the single rising-edge clock.
REQ-004 Port rst SHALL be input, 1 bit: synchronous active-high reset.
REQ-005 Port smp_valid SHALL be input, 1 bit: smp_data is valid this cycle. It is driven by the upstream Fibonacci stage's step enable.
REQ-006 Port smp_data SHALL be input, 8 bits: the Fibonacci sample from the upstream 8-bit output.
REQ-007 Port out_valid SHALL be output, 1 bit: the FIFO head is valid.
REQ-008 Port out_ready SHALL be input, 1 bit: the consumer accepts the head.
REQ-009 Port out_data SHALL be output, 16 bits: {first sample, second sample}.
REQ-010 Port out_wrap SHALL be output, 1 bit: the head word's second sample is less than its first sample (8-bit wrap).
REQ-011 Port drop_sticky SHALL be output, 1 bit: a word was lost because the FIFO was full.
REQ-012 Port fifo_count SHALL be output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-013 Port seq_err SHALL be output, 1 bit: sticky Fibonacci-sequence error (see Configuration).

Function
REQ-014 The FSM SHALL have exactly two states, EMPTY and HALF.
- EMPTY + smp_valid: latch smp_data into the hold register, go to HALF.
- HALF + smp_valid: form word {hold, smp_data} plus wrap bit (smp_data < hold), push it, go to EMPTY.
REQ-015 With smp_valid low, the FSM state and the hold register SHALL be unchanged.
REQ-016 The FIFO SHALL store DEPTH entries of 17 bits {wrap, word}, using wrapping read and write pointers.
REQ-017 A pushed word SHALL appear at out_data/out_wrap with out_valid high on the cycle after the second sample is accepted, provided the FIFO was empty.
REQ-018 out_valid SHALL equal (fifo_count != 0); out_data and out_wrap SHALL come directly from the FIFO head.
REQ-019 A pop SHALL occur when out_valid and out_ready are both high.
REQ-020 A pop with out_valid low SHALL be ignored.
REQ-021 Push to a full FIFO with no pop in the same cycle: drop the word, set drop_sticky, FSM still returns to EMPTY.
REQ-022 Push and pop in the same cycle while full SHALL both be accepted; fifo_count stays DEPTH.
REQ-023 Push and pop in the same cycle while non-full and non-empty: fifo_count unchanged.
REQ-024 Push and pop in the same cycle while empty: only the push takes effect, and the head appears on the next cycle.
REQ-025 fifo_count SHALL never exceed DEPTH.
REQ-026 Pointer wrap-around SHALL be transparent; data order SHALL be strict FIFO.
REQ-027 drop_sticky SHALL clear only on rst.

Reset
REQ-028 On rst high at a clock edge, the block SHALL enter state EMPTY and clear the hold register, pointers, fifo_count, drop_sticky, seq_err and the checker history.
REQ-029 After reset, out_valid SHALL be 0, out_data 0x0000 and out_wrap 0.
REQ-030 Reset asserted mid-operation (HALF state, or FIFO non-empty) SHALL discard the held byte and all queued words.
REQ-031 Inputs sampled in the cycle rst is high SHALL be ignored.

Configuration
REQ-032 Macro FIB_PACK_SEQ_CHECK_EN defined: the block SHALL track the last two accepted samples.
- From the third accepted sample onward, if a sample != (prev1 + prev2) mod 256, seq_err SHALL set on the following cycle and stay set until rst.
- Dropped words SHALL still update the history.
REQ-033 Macro FIB_PACK_SEQ_CHECK_EN undefined: seq_err SHALL be tied to 0 and no history registers SHALL exist.

Verification
REQ-034 Scenario: out_ready=1; samples 0x01,0x01,0x02,0x03 on consecutive cycles -> words 0x0101 (wrap 0) then 0x0203 (wrap 0), each valid one cycle after its second sample.
REQ-035 Scenario: samples 0xE9,0x79 -> out_data 0xE979, out_wrap 1.
REQ-036 Scenario: DEPTH=4, out_ready=0, 10 samples -> fifo_count 4, drop_sticky 1, then out_ready=1 -> first four words drained in order, fifo_count reaches 0.
REQ-037 Scenario: FIFO full, a 5th word pushed in the same cycle as a pop -> no drop, fifo_count stays 4, order preserved.
REQ-038 Scenario: sample 0x05 (state HALF), then rst for one cycle, then 0x08,0x0D -> single word 0x080D; 0x05 never emitted.
REQ-039 Scenario, FIB_PACK_SEQ_CHECK_EN defined: samples 0x01,0x01,0x02,0x04 -> seq_err 0 through the third sample, 1 on the cycle after 0x04; undefined -> seq_err stays 0.
